// File: rtl/led7x8_pkg.sv
// Shared constants and hex-to-segment font for the led7x8 display driver.
package led7x8_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int SEG_W      = 8;

    typedef logic [2:0] digit_t;
    typedef logic [3:0] nibble_t;

    // Active-high gfedcba patterns for 0..F
    localparam logic [6:0] FONT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] seg_font(input nibble_t nib);
        return FONT[nib];
    endfunction

endpackage

// File: rtl/led7x8_seg7_decode.sv
// Combinational hex nibble to active-high gfedcba segment decoder.
module seg7_decode
    import led7x8_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    always_comb begin
        seg = seg_font(nib);
    end

endmodule

// File: rtl/led7x8.sv
// Multiplexed 8-digit common-anode 7-segment driver with internal nibble store.
// Optional decimal-point storage and output when LED7X8_DP_EN is defined.
module led7x8
    import led7x8_pkg::*;
#(
    parameter int CLK_DIV = 10000
) (
    input  logic       clk_in,
    input  logic       init_n,
    input  logic [3:0] data,
    input  logic [2:0] addr,
    input  logic       wrn,
`ifdef LED7X8_DP_EN
    input  logic       dp,
`endif
    output logic [7:0] seg,
    output logic [7:0] pos
);

    localparam int PW = $clog2(CLK_DIV);

    logic [3:0]            mem [NUM_DIGITS];
    logic [PW-1:0]         prescaler;
    digit_t                digit;
    digit_t                digit_next;
    logic                  wrap;
    logic [6:0]            font_bits;
    logic                  dp_bit;
    logic [SEG_W-1:0]      seg_next;
    logic [NUM_DIGITS-1:0] pos_next;

`ifdef LED7X8_DP_EN
    logic [NUM_DIGITS-1:0] dp_mem;
`endif

    always_comb begin
        wrap       = (prescaler == PW'(CLK_DIV - 1));
        digit_next = wrap ? digit + 3'd1 : digit;
    end

    // Reads the pre-write store, so a write landing with a digit advance shows one edge later
    seg7_decode u_decode (
        .nib (mem[digit_next]),
        .seg (font_bits)
    );

`ifdef LED7X8_DP_EN
    always_comb dp_bit = ~dp_mem[digit_next];
`else
    always_comb dp_bit = 1'b1;
`endif

    always_comb begin
        seg_next = {dp_bit, ~font_bits};
        pos_next = ~(NUM_DIGITS'(1) << digit_next);
    end

    always_ff @(posedge clk_in or negedge init_n) begin
        if (!init_n) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                mem[i] <= '0;
            end
        end else if (!wrn) begin
            mem[addr] <= data;
        end
    end

`ifdef LED7X8_DP_EN
    always_ff @(posedge clk_in or negedge init_n) begin
        if (!init_n) begin
            dp_mem <= '0;
        end else if (!wrn) begin
            dp_mem[addr] <= dp;
        end
    end
`endif

    always_ff @(posedge clk_in or negedge init_n) begin
        if (!init_n) begin
            prescaler <= '0;
            digit     <= '0;
            seg       <= '1;
            pos       <= '1;
        end else begin
            prescaler <= wrap ? '0 : prescaler + PW'(1);
            digit     <= digit_next;
            seg       <= seg_next;
            pos       <= pos_next;
        end
    end

endmodule

// File: tb/tb_led7x8.sv
// Scoreboard bench for led7x8 (CLK_DIV=4); define LED7X8_DP_EN to cover the dp option.
module tb_led7x8;

    logic       clk_in = 1'b0;
    logic       init_n;
    logic [3:0] data;
    logic [2:0] addr;
    logic       wrn;
`ifdef LED7X8_DP_EN
    logic       dp;
`endif
    logic [7:0] seg;
    logic [7:0] pos;

    led7x8 #(.CLK_DIV(4)) dut (
        .clk_in (clk_in),
        .init_n (init_n),
        .data   (data),
        .addr   (addr),
        .wrn    (wrn),
`ifdef LED7X8_DP_EN
        .dp     (dp),
`endif
        .seg    (seg),
        .pos    (pos)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [7:0]  pos;
        logic [7:0]  seg;
        int unsigned tst;
        int unsigned k;
    } exp_t;

    exp_t q[$];
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned k = 0;

    // Active-low segment bytes for 0..F, worked out by hand from the font
    logic [7:0] font_lo [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };
    logic [3:0] sh_mem [8];
    logic [7:0] sh_dp;

    function automatic logic [7:0] exp_seg(input int unsigned d);
        logic [7:0] s;
        s = font_lo[sh_mem[d]];
`ifdef LED7X8_DP_EN
        if (sh_dp[d]) s[7] = 1'b0;
`endif
        return s;
    endfunction

    task automatic push(input logic [7:0] p, input logic [7:0] s, input int unsigned tst);
        exp_t e;
        e.pos = p;
        e.seg = s;
        e.tst = tst;
        e.k   = k;
        q.push_back(e);
    endtask

    task automatic clear_shadow();
        for (int i = 0; i < 8; i++) sh_mem[i] = 4'h0;
        sh_dp = 8'h00;
    endtask

    // Each cycle: expected outputs for the coming edge use the store as it was before that edge
    task automatic run(input int unsigned n, input int unsigned tst);
        for (int unsigned i = 0; i < n; i++) begin
            int unsigned d;
            d = ((k + 1) / 4) % 8;
            push(~(8'h01 << d), exp_seg(d), tst);
            if (!wrn) begin
                sh_mem[addr] = data;
`ifdef LED7X8_DP_EN
                sh_dp[addr] = dp;
`endif
            end
            @(negedge clk_in);
            #1;
            k++;
        end
    endtask

    always @(negedge clk_in) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (pos !== e.pos || seg !== e.seg) begin
                errors++;
                $display("FAIL scan t%0d k%0d: pos=%h seg=%h, expected pos=%h seg=%h",
                         e.tst, e.k, pos, seg, e.pos, e.seg);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] vals [8];
        vals = '{4'hF, 4'hB, 4'h8, 4'h0, 4'hA, 4'hD, 4'hE, 4'h1};

        init_n = 1'b0;
        wrn    = 1'b1;
        data   = 4'h0;
        addr   = 3'd0;
`ifdef LED7X8_DP_EN
        dp     = 1'b0;
`endif
        clear_shadow();

        // 1: reset held three cycles, then release
        for (int i = 0; i < 3; i++) begin
            push(8'hFF, 8'hFF, 1);
            @(negedge clk_in);
            #1;
        end
        init_n = 1'b1;
        k = 0;

        // 2: free scan over a full frame plus wrap
        run(36, 2);

        // 3: single write to digit 3
        data = 4'h5; addr = 3'd3; wrn = 1'b0;
        run(1, 3);
        wrn = 1'b1;
        run(32, 3);

        // 4: fill all digits
        for (int i = 0; i < 8; i++) begin
            addr = 3'(i); data = vals[i]; wrn = 1'b0;
            run(1, 4);
        end
        wrn = 1'b1;
        run(32, 4);

        // 5: address/data churn with strobe high, then async reset mid-dwell
        for (int i = 0; i < 32; i++) begin
            addr = 3'($urandom_range(7));
            data = 4'($urandom_range(15));
            run(1, 5);
        end
        run(2, 5);
        init_n = 1'b0;
        #1;
        checks++;
        if (pos !== 8'hFF || seg !== 8'hFF) begin
            errors++;
            $display("FAIL async_reset: pos=%h seg=%h, expected pos=ff seg=ff", pos, seg);
        end
        push(8'hFF, 8'hFF, 5);
        @(negedge clk_in);
        #1;
        clear_shadow();
        init_n = 1'b1;
        k = 0;
        run(34, 5);

        // 6: decimal point (constant dark without the option)
        data = 4'h2; addr = 3'd0; wrn = 1'b0;
`ifdef LED7X8_DP_EN
        dp = 1'b1;
`endif
        run(1, 6);
        wrn = 1'b1;
`ifdef LED7X8_DP_EN
        dp = 1'b0;
`endif
        run(34, 6);

        for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk_in);
        #1;
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
